// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute stage and the multiply/divide unit
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues operations and HI/LO writes, watches busy/done.
    modport master (
        output start, op, A, B, mthi, mtlo, wdata,
        input  busy, done, HI, LO
    );

    // Unit side.
    modport slave (
        input  start, op, A, B, mthi, mtlo, wdata,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle mult/multu/div/divu unit owning the HI/LO registers
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] ub_safe;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_by_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Result datapath, evaluated from the operands latched at the start edge.
    always_comb begin
        // Sign-extending into 64 bits makes the low 64 bits of an unsigned
        // product equal to the two's-complement product, so one multiplier
        // serves both mult and multu.
        mul_a   = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
        mul_b   = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
        product = mul_a * mul_b;

        // Divide on magnitudes then fix signs: quotient truncates toward zero,
        // remainder follows the dividend. 0x80000000 / -1 wraps back to
        // 0x80000000 with remainder 0 through this path.
        div_signed  = ~op_q[0];
        a_neg       = div_signed & a_q[31];
        b_neg       = div_signed & b_q[31];
        ua          = a_neg ? (32'd0 - a_q) : a_q;
        ub          = b_neg ? (32'd0 - b_q) : b_q;
        div_by_zero = (b_q == 32'd0);
        ub_safe     = div_by_zero ? 32'd1 : ub;
        uq          = ua / ub_safe;
        ur          = ua % ub_safe;
        quo         = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem         = a_neg ? (32'd0 - ur) : ur;

        res_hi = op_q[1] ? rem : product[63:32];
        res_lo = op_q[1] ? quo : product[31:0];
    end

    // Control FSM: accepts start or mthi/mtlo in IDLE, counts down in RUN and commits on the last count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= 2'b00;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // start takes priority; a simultaneous mthi/mtlo is dropped
                        op_q   <= bus.op;
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        cnt    <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (bus.mthi) begin
                            hi_q <= bus.wdata;
                        end
                        if (bus.mtlo) begin
                            lo_q <= bus.wdata;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        // a zero divisor still takes the full time but leaves HI/LO alone
                        if (!(op_q[1] && div_by_zero)) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule
